// File: rtl/uart_intr_ctrl.sv
// UART interrupt controller: sticky RX line errors, IER, prioritised
// interrupt source selection with a 16550-style IIR and a registered host interrupt.
module uart_intr_ctrl #(
  parameter int          TIMEOUT  = 1024,
  parameter logic [15:0] IER_ADDR = 16'h0001,
  parameter logic [15:0] IIR_ADDR = 16'h0002,
  parameter logic [15:0] LSR_ADDR = 16'h0004,
  parameter logic [15:0] THR_ADDR = 16'h0000
) (
  input  logic        m_clk,
  input  logic        reset,
  input  logic [15:0] address,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  input  logic        start_bit_error,
  input  logic        parity_bit_error,
  input  logic        framing_stop_error,
  input  logic        trigger_RX,
  input  logic        rd_empty_RX,
  input  logic        rx_push,
  input  logic        rx_pop,
  input  logic        rd_empty_TX,
  output logic [2:0]  err_sticky,
  output logic        intr
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    ID_NONE,
    ID_LS,
    ID_RDA,
    ID_CTO,
    ID_THRE
  } id_t;

  id_t           cur_id;
  id_t           nxt_id;
  logic [3:0]    ier;
  logic          thre_pend;
  logic          tx_empty_q;
  logic [CW-1:0] tout_cnt;

  logic       ier_wr, thr_wr, lsr_rd, iir_rd, ier_rd;
  logic       cto;
  logic       thre_set, thre_clr;
  logic [2:0] err_in;
  logic       unused_data_bits;

  assign ier_wr = wr_en && (address == IER_ADDR);
  assign thr_wr = wr_en && (address == THR_ADDR);
  assign lsr_rd = rd_en && (address == LSR_ADDR);
  assign iir_rd = rd_en && (address == IIR_ADDR);
  assign ier_rd = rd_en && (address == IER_ADDR);

  assign err_in = {start_bit_error, parity_bit_error, framing_stop_error};
  assign cto    = (tout_cnt == CW'(TIMEOUT));

  // THRE arms on TX FIFO becoming empty, or when the host enables it while already empty.
  assign thre_set = (rd_empty_TX && !tx_empty_q) ||
                    (ier_wr && data_in[1] && !ier[1] && rd_empty_TX);
  assign thre_clr = thr_wr || (iir_rd && (cur_id == ID_THRE));

  assign unused_data_bits = ^data_in[7:4];

  function automatic logic [7:0] iir_code(input id_t id);
    case (id)
      ID_LS:   iir_code = 8'h06;
      ID_RDA:  iir_code = 8'h04;
      ID_CTO:  iir_code = 8'h0C;
      ID_THRE: iir_code = 8'h02;
      default: iir_code = 8'h01;
    endcase
  endfunction

  always_comb begin
    nxt_id = ID_NONE;
    if ((|err_sticky) && ier[2])  nxt_id = ID_LS;
    else if (trigger_RX && ier[0]) nxt_id = ID_RDA;
    else if (cto && ier[3])        nxt_id = ID_CTO;
    else if (thre_pend && ier[1])  nxt_id = ID_THRE;
  end

  always_ff @(posedge m_clk or negedge reset) begin
    if (!reset) begin
      ier        <= 4'h0;
      err_sticky <= 3'b000;
      thre_pend  <= 1'b0;
      tx_empty_q <= 1'b1;
      tout_cnt   <= '0;
    end else begin
      if (ier_wr) ier <= data_in[3:0];
      // A new error in the same cycle as the LSR read survives the clear.
      err_sticky <= (lsr_rd ? 3'b000 : err_sticky) | err_in;
      tx_empty_q <= rd_empty_TX;
      if (thre_set)      thre_pend <= 1'b1;
      else if (thre_clr) thre_pend <= 1'b0;
      if (rd_empty_RX || rx_push || rx_pop) tout_cnt <= '0;
      else if (!cto)                        tout_cnt <= tout_cnt + CW'(1);
    end
  end

  always_ff @(posedge m_clk or negedge reset) begin
    if (!reset) begin
      cur_id   <= ID_NONE;
      intr     <= 1'b0;
      data_out <= 8'h00;
    end else begin
      cur_id <= nxt_id;
      intr   <= (nxt_id != ID_NONE);
      if (iir_rd)      data_out <= iir_code(cur_id);
      else if (ier_rd) data_out <= {4'b0000, ier};
    end
  end

endmodule

// File: doc/uart_intr_ctrl.md
Name: uart_intr_ctrl

Overview:
Interrupt controller and status sequencer for the UART register block. It latches the RX line errors (start, parity, framing) as sticky status bits and holds the interrupt-enable register (IER). It prioritises four interrupt sources and presents a 16550-style interrupt identification register (IIR). It drives a single interrupt line to the host, and clears sources according to host read and write handshakes.

Parameters:
TIMEOUT, 1024, m_clk cycles of RX FIFO inactivity (non-empty, no push or pop) before a character-timeout interrupt is raised.
IER_ADDR, 16'h0001, address of the interrupt-enable register.
IIR_ADDR, 16'h0002, address of the interrupt-identification register (read-only).
LSR_ADDR, 16'h0004, address of the line status register; a read here clears the sticky errors.
THR_ADDR, 16'h0000, address of the transmit holding register; a write here clears the THRE interrupt.

Ports:
m_clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
address  input  16  host register address
wr_en  input  1  host write strobe, one cycle
rd_en  input  1  host read strobe, one cycle
data_in  input  8  host write data
data_out  output  8  registered read data (IER/IIR)
start_bit_error  input  1  RX start-bit error pulse/level
parity_bit_error  input  1  RX parity error pulse/level
framing_stop_error  input  1  RX framing error pulse/level
trigger_RX  input  1  RX FIFO at/above trigger level
rd_empty_RX  input  1  RX FIFO empty
rx_push  input  1  byte written into RX FIFO this cycle
rx_pop  input  1  byte read from RX FIFO this cycle
rd_empty_TX  input  1  TX FIFO empty
err_sticky  output  3  {start, parity, framing} sticky errors, feed LSR bits 7:5
intr  output  1  interrupt to host, active-high, registered

Behaviour:
- Reset (reset=0, async): ier=0, err_sticky=0, thre_pend=0, tout_cnt=0, cur_id=NONE, data_out=8'h00, intr=0.
- IER write: wr_en & address==IER_ADDR loads ier <= data_in[3:0]; bits 7:4 ignored.
  - Bit 0 enables RDA, bit 1 THRE, bit 2 LS, bit 3 CTO.
- Sticky errors: each bit is set in any cycle its error input is 1.
  - Cleared on rd_en & address==LSR_ADDR.
  - If set and clear occur in the same cycle, set wins.
- THRE pending is set on either of:
  - the rising edge of rd_empty_TX (registered previous value used);
  - an IER write taking bit1 0->1 while rd_empty_TX=1.
- THRE pending is cleared on wr_en & address==THR_ADDR, or on an IIR read that returns the THRE code.
  - If set and clear occur in the same cycle, set wins.
- Timeout counter: reset to 0 when rd_empty_RX=1, rx_push=1 or rx_pop=1; otherwise increments, saturating at TIMEOUT.
  - CTO pending while tout_cnt==TIMEOUT.
- Source state machine, states NONE/LS/RDA/CTO/THRE, re-evaluated every cycle from enabled pending sources in fixed priority:
  - LS: |err_sticky & ier[2].
  - RDA: trigger_RX & ier[0].
  - CTO: cto & ier[3].
  - THRE: thre_pend & ier[1].
  - NONE otherwise.
  - The registered cur_id is updated one cycle after a source changes.
- IIR codes: NONE=8'h01, LS=8'h06, RDA=8'h04, CTO=8'h0C, THRE=8'h02.
- intr <= (next state != NONE); latency one m_clk from a source becoming pending and enabled.
- Reads: rd_en & address==IIR_ADDR sets data_out <= code of cur_id on the next edge.
  - rd_en & address==IER_ADDR sets data_out <= {4'b0, ier}.
  - Other addresses leave data_out unchanged.
- An IIR read returning THRE clears thre_pend the same edge; intr drops the following cycle unless another source is pending.
- LS and RDA/CTO are not cleared by an IIR read.
  - They clear only by an LSR read, FIFO level drop below trigger, or rx_pop respectively.
- Read and write in the same cycle to different addresses are both honoured.
- Reset mid-operation clears all state immediately; there is no pending-interrupt memory across reset.

Test Plan:
- Reset, then read IIR -> data_out=8'h01, intr=0, err_sticky=3'b000.
- Write IER=8'h04, pulse parity_bit_error one cycle -> err_sticky=3'b010; intr=1 after 1 cycle; IIR reads 8'h06; LSR read -> err_sticky=0, intr=0 next cycle.
- IER=8'h0F, trigger_RX=1 and thre_pend both active -> IIR=8'h04; drop trigger_RX -> IIR=8'h02; IIR read clears THRE -> intr=0, next IIR=8'h01.
- IER=8'h08, TIMEOUT=16, rd_empty_RX=0 with no push/pop -> intr asserts exactly 17 cycles after the last activity, IIR=8'h0C; rx_pop=1 -> intr=0 next cycle.
- LSR read in the same cycle as framing_stop_error=1 -> err_sticky[0] remains 1 (set wins).
- Assert reset=0 asynchronously while intr=1 and IER=8'h0F -> intr=0, ier=0, data_out=0 without waiting for an m_clk edge.
